// File: rtl/dmux_pkg.sv
// Shared types and constants for the lane demultiplexing scheduler.
// Lane count, select width and the IDLE/HOLD state encoding live here.
package dmux_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Round-robin successor; the 2-bit add wraps 3 back to 0.
  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] cur);
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/dmux_scheduler_dmux4way.sv
// One-to-four demultiplexer: routes a single flag onto the output selected by sel.
module dmux4way
  import dmux_pkg::*;
(
  input  logic             in,
  input  logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] out
);

  // One-hot steering of the input flag to the selected lane
  always_comb begin
    out = {LANES{1'b0}};
    case (sel)
      2'd0:    out[0] = in;
      2'd1:    out[1] = in;
      2'd2:    out[2] = in;
      2'd3:    out[3] = in;
      default: out = {LANES{1'b0}};
    endcase
  end

endmodule

// File: rtl/dmux_scheduler.sv
// Single-word-buffered scheduler that steers an upstream stream onto four lanes,
// either round-robin in bursts of BURST words or to a fixed lane.
module dmux_scheduler
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BURST = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  input  logic [SEL_W-1:0] fixed_sel,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] lane
);

  localparam logic [7:0] BURST_L = 8'(BURST);

  state_e           state_r;
  state_e           state_s;
  logic [SEL_W-1:0] ptr_r;
  logic [7:0]       cnt_r;
  logic [WIDTH-1:0] data_r;
  logic [SEL_W-1:0] lane_r;

  logic             hold_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             deliver_s;
  logic [SEL_W-1:0] new_lane_s;
  logic [7:0]       cnt_inc_s;

  // Handshake decode and next-state selection
  always_comb begin
    hold_s    = (state_r == HOLD);
    deliver_s = hold_s & out_ready[lane_r];
    if (hold_s) begin
      in_ready_s = out_ready[lane_r];
    end else begin
      in_ready_s = 1'b1;
    end
    accept_s = in_valid & in_ready_s;
    if (mode) begin
      new_lane_s = fixed_sel;
    end else begin
      new_lane_s = ptr_r;
    end
    cnt_inc_s = cnt_r + 8'd1;
    state_s   = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = HOLD;
        else          state_s = IDLE;
      end
      HOLD: begin
        // A delivery paired with a fresh accept keeps the buffer full.
        if (deliver_s && !accept_s) state_s = IDLE;
        else                        state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer and burst counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      if (accept_s && !mode) begin
        if (cnt_inc_s == BURST_L) begin
          cnt_r <= 8'd0;
          ptr_r <= next_lane(ptr_r);
        end else begin
          cnt_r <= cnt_inc_s;
        end
      end
    end
  end

  // Datapath: held word and its lane; lane falls back to the pointer once emptied
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r <= {WIDTH{1'b0}};
      lane_r <= 2'd0;
    end else if (accept_s) begin
      data_r <= in_data;
      lane_r <= new_lane_s;
    end else if (deliver_s) begin
      lane_r <= ptr_r;
    end
  end

  dmux4way u_valid_dmux (
    .in  (hold_s),
    .sel (lane_r),
    .out (out_valid)
  );

  assign in_ready = in_ready_s;
  assign out_data = data_r;
  assign lane     = lane_r;

endmodule

// File: tb/tb_dmux_scheduler.sv
// Directed and scoreboarded bench for dmux_scheduler; u_dut1 runs BURST=1, u_dut2 BURST=2.
module tb_dmux_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        iv1;
  logic        iv2;
  logic [15:0] din;
  logic        mode;
  logic [1:0]  fsel;
  logic [3:0]  ordy;

  logic        rdy1, rdy2;
  logic [3:0]  ov1, ov2;
  logic [15:0] od1, od2;
  logic [1:0]  ln1, ln2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dmux_scheduler #(.WIDTH(16), .BURST(1)) u_dut1 (
    .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(rdy1), .in_data(din),
    .mode(mode), .fixed_sel(fsel), .out_valid(ov1), .out_ready(ordy),
    .out_data(od1), .lane(ln1)
  );

  dmux_scheduler #(.WIDTH(16), .BURST(2)) u_dut2 (
    .clock(clock), .reset(reset), .in_valid(iv2), .in_ready(rdy2), .in_data(din),
    .mode(mode), .fixed_sel(fsel), .out_valid(ov2), .out_ready(ordy),
    .out_data(od2), .lane(ln2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [3:0]  exp4;
  logic [1:0]  lanes_b2 [6];
  logic [1:0]  lanes_wrap [4];
  logic [15:0] q [4][$];
  logic        m_hold;
  logic [1:0]  m_lane;
  logic [1:0]  m_ptr;
  logic [1:0]  nl;
  logic        exp_rdy;
  logic        acc;
  logic        del;
  int          n_acc;
  int          n_del;

  initial begin
    reset = 1'b1; iv1 = 1'b0; iv2 = 1'b0; din = 16'h0000;
    mode = 1'b0; fsel = 2'd0; ordy = 4'hF;
    lanes_b2   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    lanes_wrap = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    #2;
    chk("rst_out_valid", ov1, 4'b0000);
    chk("rst_lane", ln1, 2'd0);
    chk("rst_out_data", od1, 16'h0000);
    chk("rst_out_valid_b2", ov2, 4'b0000);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", rdy1, 1'b1);
    tick();

    // BURST=1 round robin, back-to-back words 1..5
    for (int i = 0; i <= 5; i++) begin
      iv1 = (i < 5);
      din = 16'(i + 1);
      @(negedge clock);
      chk("rr1_in_ready", rdy1, 1'b1);
      if (i > 0) begin
        exp4 = 4'b0001 << ((i - 1) % 4);
        chk("rr1_out_valid", ov1, exp4);
        chk("rr1_out_data", od1, 32'(i));
      end
      tick();
    end
    @(negedge clock);
    chk("rr1_idle_valid", ov1, 4'b0000);
    chk("rr1_idle_ptr", ln1, 2'd1);
    tick();

    // BURST=2 round robin, six words
    for (int i = 0; i <= 6; i++) begin
      iv2 = (i < 6);
      din = 16'(16'h0100 + i);
      @(negedge clock);
      if (i > 0) begin
        chk("b2_lane", ln2, lanes_b2[i-1]);
        exp4 = 4'b0001 << lanes_b2[i-1];
        chk("b2_out_valid", ov2, exp4);
        chk("b2_out_data", od2, 32'(16'h0100 + i - 1));
      end
      tick();
    end
    @(negedge clock);
    chk("b2_idle_valid", ov2, 4'b0000);
    chk("b2_idle_ptr", ln2, 2'd3);
    tick();

    // Fixed lane 2 with that lane stalled for three cycles
    mode = 1'b1; fsel = 2'd2; ordy = 4'b1011; iv1 = 1'b1; din = 16'hABCD;
    tick();
    din = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("fix_out_valid", ov1, 4'b0100);
      chk("fix_in_ready", rdy1, 1'b0);
      chk("fix_out_data", od1, 16'hABCD);
      tick();
    end
    iv1 = 1'b0; ordy = 4'hF;
    @(negedge clock);
    chk("fix_release_ready", rdy1, 1'b1);
    chk("fix_release_valid", ov1, 4'b0100);
    tick();
    @(negedge clock);
    chk("fix_idle_valid", ov1, 4'b0000);
    chk("fix_ptr_kept", ln1, 2'd1);
    chk("fix_data_kept", od1, 16'hABCD);
    mode = 1'b0;
    tick();

    // Pointer walks 1,2,3 and wraps to 0
    for (int i = 0; i <= 4; i++) begin
      iv1 = (i < 4);
      din = 16'(16'h0010 + i);
      @(negedge clock);
      if (i > 0) begin
        chk("wrap_lane", ln1, lanes_wrap[i-1]);
        chk("wrap_out_data", od1, 32'(16'h0010 + i - 1));
      end
      tick();
    end

    // Reset mid-cycle while a word is stalled on lane 1
    ordy = 4'b0000; iv1 = 1'b1; din = 16'h7777;
    tick();
    iv1 = 1'b0;
    @(negedge clock);
    chk("hold_lane1_valid", ov1, 4'b0010);
    chk("hold_lane1_ready", rdy1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", ov1, 4'b0000);
    chk("async_rst_lane", ln1, 2'd0);
    chk("async_rst_data", od1, 16'h0000);
    tick();
    ordy = 4'hF;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", rdy1, 1'b1);
    chk("post_rst_lane", ln1, 2'd0);
    chk("post_rst_valid", ov1, 4'b0000);
    tick();
    @(negedge clock);
    chk("no_stale_delivery", ov1, 4'b0000);
    tick();

    // Random handshake traffic against a reference model
    m_hold = 1'b0; m_lane = 2'd0; m_ptr = 2'd0; n_acc = 0; n_del = 0;
    for (int c = 0; c < 1010; c++) begin
      if (c < 1000) begin
        iv1  = 1'($urandom_range(0, 1));
        mode = ($urandom_range(0, 3) == 0);
        fsel = 2'($urandom_range(0, 3));
        ordy = 4'($urandom_range(0, 15));
        din  = 16'($urandom);
      end else begin
        iv1 = 1'b0; ordy = 4'hF;
      end
      @(negedge clock);
      exp_rdy = !m_hold || ordy[m_lane];
      exp4 = m_hold ? (4'b0001 << m_lane) : 4'b0000;
      chk("sb_in_ready", rdy1, exp_rdy);
      chk("sb_out_valid", ov1, exp4);
      chk("sb_lane", ln1, m_hold ? m_lane : m_ptr);
      del = m_hold && ordy[m_lane];
      acc = iv1 && exp_rdy;
      if (del) begin
        n_del++;
        if (q[m_lane].size() > 0) chk("sb_data_order", od1, q[m_lane].pop_front());
      end
      if (acc) begin
        nl = mode ? fsel : m_ptr;
        q[nl].push_back(din);
        n_acc++;
        if (!mode) m_ptr = m_ptr + 2'd1;
        m_lane = nl;
        m_hold = 1'b1;
      end else if (del) begin
        m_hold = 1'b0;
      end
      tick();
    end
    chk("sb_accept_eq_delivery", n_acc, n_del);
    @(negedge clock);
    chk("sb_drained_valid", ov1, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
